// File: rtl/counter_chain_pkg.sv
// Shared definitions for the counter chain: stage slicing and standard
// time-of-day bounds (seconds, minutes, hours).
`ifndef COUNTER_CHAIN_PKG_SV
`define COUNTER_CHAIN_PKG_SV

// Part-select of stage k in a packed bus of w-bit stages.
`define CC_SLICE(k, w) ((k)*(w)) +: (w)

package counter_chain_pkg;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

endpackage

`endif

// File: rtl/counter_chain_stage.sv
// One modular up/down counter stage with carry/borrow pass-through.
// Ports: clk_i, rst_i, min_i, max_i, carry_i, borrow_i, clr_i, load_i,
//        load_value_i in; value_o, carry_o, borrow_o, wrap_o out.
module counter_chain_stage
    import counter_chain_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] min_i,
    input  logic [WIDTH-1:0] max_i,
    input  logic             carry_i,
    input  logic             borrow_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] value_o,
    output logic             carry_o,
    output logic             borrow_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] r_value;
    logic             w_at_max;
    logic             w_at_min;

    // Inequalities (not equality) so out-of-range values still wrap.
    assign w_at_max = (r_value >= max_i);
    assign w_at_min = (r_value <= min_i);

    assign carry_o  = carry_i & w_at_max;
    assign borrow_o = borrow_i & w_at_min;
    assign wrap_o   = carry_o | borrow_o;
    assign value_o  = r_value;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_value <= '0;
        end else if (clr_i) begin
            r_value <= min_i;
        end else if (load_i) begin
            r_value <= load_value_i;
        end else if (carry_i) begin
            r_value <= w_at_max ? min_i : r_value + 1'b1;
        end else if (borrow_i) begin
            r_value <= w_at_min ? max_i : r_value - 1'b1;
        end
    end

endmodule

// File: rtl/counter_chain.sv
// Cascade of modular up/down counters with ripple carry/borrow (stage 0 LSB).
// Ports: clk_i, rst_i, min_i, max_i, inc_i, dec_i, clr_i, load_i,
//        load_value_i in; value_o, wrap_o, ovf_o, unf_o out.
module counter_chain
    import counter_chain_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int WIDTH      = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_STAGES*WIDTH-1:0] min_i,
    input  logic [NUM_STAGES*WIDTH-1:0] max_i,
    input  logic                        inc_i,
    input  logic                        dec_i,
    input  logic                        clr_i,
    input  logic                        load_i,
    input  logic [NUM_STAGES*WIDTH-1:0] load_value_i,
    output logic [NUM_STAGES*WIDTH-1:0] value_o,
    output logic [NUM_STAGES-1:0]       wrap_o,
    output logic                        ovf_o,
    output logic                        unf_o
);

    logic                  w_step_ok;
    logic [NUM_STAGES:0]   w_carry;
    logic [NUM_STAGES:0]   w_borrow;

    // Clear, load and reset all block stepping, which also silences flags.
    assign w_step_ok   = ~(clr_i | load_i | rst_i);
    assign w_carry[0]  = w_step_ok & inc_i & ~dec_i;
    assign w_borrow[0] = w_step_ok & dec_i & ~inc_i;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        counter_chain_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk_i        (clk_i),
            .rst_i        (rst_i),
            .min_i        (min_i[`CC_SLICE(k, WIDTH)]),
            .max_i        (max_i[`CC_SLICE(k, WIDTH)]),
            .carry_i      (w_carry[k]),
            .borrow_i     (w_borrow[k]),
            .clr_i        (clr_i),
            .load_i       (load_i),
            .load_value_i (load_value_i[`CC_SLICE(k, WIDTH)]),
            .value_o      (value_o[`CC_SLICE(k, WIDTH)]),
            .carry_o      (w_carry[k+1]),
            .borrow_o     (w_borrow[k+1]),
            .wrap_o       (wrap_o[k])
        );
    end

    assign ovf_o = w_carry[NUM_STAGES];
    assign unf_o = w_borrow[NUM_STAGES];

endmodule
